// File: rtl/regfile_reader.sv
// Burst reader: streams count words from a register file, starting at base_addr,
// out through a valid/ready register slice with a last-word marker.
module regfile_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DATA_D = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic              abort_,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'(DATA_D);
  localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_D - 1);

  state_t          state;
  logic [ADDR_W:0] remaining;
  logic [ADDR_W:0] clamped;
  logic            load;

  always_comb begin
    clamped = count;
    if (count > DEPTH) clamped = DEPTH;
  end

  // The output register refills whenever it is empty or being drained this cycle.
  assign load   = (state == RUN) && (!m_valid || m_ready);
  assign busy   = (state != IDLE);
  assign rf_we_ = 1'b1;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      rf_addr   <= '0;
      remaining <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_addr    <= '0;
      m_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!abort_) begin
        state   <= IDLE;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (clamped == '0) begin
                done <= 1'b1;
              end else begin
                state     <= RUN;
                rf_addr   <= base_addr;
                remaining <= clamped;
              end
            end
          end
          RUN: begin
            if (load) begin
              m_data    <= rf_d_out;
              m_addr    <= rf_addr;
              m_valid   <= 1'b1;
              m_last    <= (remaining == ONE_WORD);
              remaining <= remaining - ONE_WORD;
              rf_addr   <= (rf_addr == LAST_ADDR) ? '0 : rf_addr + ADDR_W'(1);
              if (remaining == ONE_WORD) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: a table of bursts checked beat by beat
// against a register-file model, plus hand-written abort and reset sequences.
module tb_regfile_reader;

  logic        clk;
  logic        reset_;
  logic        start;
  logic        abort_;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic [4:0]  rf_addr;
  logic        rf_we_;
  logic [31:0] rf_d_out;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] ff [32];
  int total;
  int bad;

  typedef struct {
    logic [4:0] base;
    logic [5:0] count;
    logic [3:0] ready_pat;
    int         beats;
  } burst_vec_t;

  burst_vec_t vecs [6];

  regfile_reader #(.ADDR_W(5), .DATA_W(32), .DATA_D(32)) dut (
    .clk(clk), .reset_(reset_), .start(start), .abort_(abort_),
    .base_addr(base_addr), .count(count), .rf_addr(rf_addr), .rf_we_(rf_we_),
    .rf_d_out(rf_d_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last), .busy(busy), .done(done)
  );

  assign rf_d_out = ff[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input logic [31:0] act, input logic [31:0] exp, input string name);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge; runs one burst and checks every beat against the model.
  task automatic apply_stimulus(input burst_vec_t v);
    int          beats;
    int          last_hs;
    logic        stalled;
    logic        got_done;
    logic [31:0] hold_data;
    logic [4:0]  hold_addr;
    logic        hold_last;
    logic [4:0]  exp_addr;
    beats = 0; last_hs = -1; stalled = 1'b0; got_done = 1'b0;
    hold_data = '0; hold_addr = '0; hold_last = 1'b0;
    start = 1'b1; base_addr = v.base; count = v.count; m_ready = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc < 200 && !got_done; cyc++) begin
      m_ready = v.ready_pat[(cyc - 1) % 4];
      if (cyc == 1 && v.beats != 0) check_output(32'(busy), 32'd1, "busy_after_start");
      if (cyc == 2 && v.beats != 0) check_output(32'(m_valid), 32'd1, "first_valid_latency");
      if (stalled) begin
        check_output(32'(m_valid), 32'd1, "stall_valid");
        check_output(m_data, hold_data, "stall_data");
        check_output(32'(m_addr), 32'(hold_addr), "stall_addr");
        check_output(32'(m_last), 32'(hold_last), "stall_last");
      end
      if (beats == v.beats && (last_hs == cyc - 1 || (v.beats == 0 && cyc == 1))) begin
        check_output(32'(done), 32'd1, "done_pulse");
        check_output(32'(busy), 32'd0, "idle_after_done");
        got_done = 1'b1;
      end else begin
        check_output(32'(done), 32'd0, "done_early");
      end
      if (m_valid && m_ready) begin
        if (beats >= v.beats) begin
          check_output(32'(beats), 32'(v.beats - 1), "extra_beat");
        end else begin
          exp_addr = 5'((int'(v.base) + beats) % 32);
          check_output(32'(m_addr), 32'(exp_addr), "beat_addr");
          check_output(m_data, 32'(exp_addr) + 32'h100, "beat_data");
          check_output(32'(m_last), 32'(beats == v.beats - 1), "beat_last");
        end
        beats++;
        if (beats == v.beats) last_hs = cyc;
      end
      stalled = m_valid && !m_ready;
      hold_data = m_data; hold_addr = m_addr; hold_last = m_last;
      if (!got_done) next_cycle();
    end
    check_output(32'(beats), 32'(v.beats), "beat_count");
    check_output(32'(got_done), 32'd1, "done_seen");
    if (v.ready_pat == 4'hF && v.beats > 0)
      check_output(32'(last_hs), 32'(v.beats + 1), "back_to_back");
    m_ready = 1'b0;
    next_cycle();
    check_output(32'(done), 32'd0, "done_one_cycle");
  endtask

  task automatic check_reset_values(input string name);
    check_output(32'(m_valid), 32'd0, {name, "_m_valid"});
    check_output(32'(m_last), 32'd0, {name, "_m_last"});
    check_output(m_data, 32'd0, {name, "_m_data"});
    check_output(32'(m_addr), 32'd0, {name, "_m_addr"});
    check_output(32'(rf_addr), 32'd0, {name, "_rf_addr"});
    check_output(32'(busy), 32'd0, {name, "_busy"});
    check_output(32'(done), 32'd0, {name, "_done"});
    check_output(32'(rf_we_), 32'd1, {name, "_rf_we"});
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 32; i++) ff[i] = 32'h100 + 32'(i);
    vecs[0] = '{base: 5'd0,  count: 6'd4,  ready_pat: 4'hF,    beats: 4};
    vecs[1] = '{base: 5'd30, count: 6'd4,  ready_pat: 4'hF,    beats: 4};
    vecs[2] = '{base: 5'd5,  count: 6'd6,  ready_pat: 4'b1001, beats: 6};
    vecs[3] = '{base: 5'd3,  count: 6'd40, ready_pat: 4'hF,    beats: 32};
    vecs[4] = '{base: 5'd7,  count: 6'd0,  ready_pat: 4'hF,    beats: 0};
    vecs[5] = '{base: 5'd31, count: 6'd32, ready_pat: 4'b1011, beats: 32};

    reset_ = 1'b0; start = 1'b0; abort_ = 1'b1; base_addr = '0; count = '0; m_ready = 1'b0;
    #2;
    check_reset_values("reset_init");
    @(negedge clk);
    reset_ = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Abort after two beats have been accepted.
    start = 1'b1; base_addr = 5'd0; count = 6'd8; m_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (3) next_cycle();
    abort_ = 1'b0;
    next_cycle();
    abort_ = 1'b1;
    check_output(32'(m_valid), 32'd0, "abort_valid");
    check_output(32'(busy), 32'd0, "abort_busy");
    check_output(32'(done), 32'd0, "abort_done");
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check_output(32'(done | m_valid | busy), 32'd0, "abort_quiet");
    end

    // Abort coinciding with start must win.
    start = 1'b1; abort_ = 1'b0; count = 6'd4;
    next_cycle();
    start = 1'b0; abort_ = 1'b1;
    check_output(32'(busy), 32'd0, "abort_start_busy");
    next_cycle();
    check_output(32'(done | m_valid), 32'd0, "abort_start_quiet");

    // Reset mid-burst, then a fresh burst.
    start = 1'b1; base_addr = 5'd0; count = 6'd8; m_ready = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (3) next_cycle();
    #2;
    reset_ = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (2) next_cycle();
    check_output(32'(done), 32'd0, "reset_no_done");
    @(negedge clk);
    reset_ = 1'b1;
    next_cycle();
    apply_stimulus('{base: 5'd2, count: 6'd3, ready_pat: 4'hF, beats: 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, giving the register-file address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the register-file data width.
REQ-003 The block SHALL have parameter DATA_D, default 32, giving the register-file depth, a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The block SHALL have port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a burst read, sampled only in IDLE.
REQ-007 The block SHALL have port abort_, input, 1 bit: synchronous active-low burst cancel.
REQ-008 The block SHALL have port base_addr, input, ADDR_W bits: first register-file address of the burst.
REQ-009 The block SHALL have port count, input, ADDR_W+1 bits: number of words to read.
REQ-010 The block SHALL have port rf_addr, output, ADDR_W bits: register-file read address.
REQ-011 The block SHALL have port rf_we_, output, 1 bit: register-file write enable, active-low, held at 1.
REQ-012 The block SHALL have port rf_d_out, input, DATA_W bits: combinational register-file read data at rf_addr.
REQ-013 The block SHALL have port m_valid, output, 1 bit: stream word valid.
REQ-014 The block SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-015 The block SHALL have port m_data, output, DATA_W bits: stream word.
REQ-016 The block SHALL have port m_addr, output, ADDR_W bits: source address of m_data.
REQ-017 The block SHALL have port m_last, output, 1 bit: marks the final word of the burst.
REQ-018 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-020 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-021 IDLE -> RUN SHALL occur when start=1 and the clamped count is nonzero; start SHALL be ignored while busy=1.
REQ-022 A count greater than DATA_D SHALL be clamped to DATA_D.
REQ-023 start with count=0 SHALL stay in IDLE, emit no beats and pulse done on the next cycle.
REQ-024 In RUN, rf_addr SHALL equal base_addr on the first RUN cycle and SHALL advance by 1 modulo DATA_D per word loaded, wrapping from DATA_D-1 to 0.
REQ-025 A word SHALL be loaded into the output register (m_data<=rf_d_out, m_addr<=rf_addr) when in RUN and (m_valid=0 or m_ready=1).
REQ-026 Sustained throughput SHALL be one word per cycle while m_ready=1; first m_valid SHALL occur 2 cycles after the cycle that samples start.
REQ-027 m_valid, m_data, m_addr and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-028 m_last SHALL be 1 exactly on the word whose load exhausts the remaining count.
REQ-029 RUN -> DRAIN SHALL occur on the load of the last word; DRAIN -> IDLE SHALL occur on the handshake of that word.
REQ-030 done SHALL pulse for one cycle on the cycle after the last-word handshake.
REQ-031 When abort_=0, the next state SHALL be IDLE with m_valid=0 and no done, in any state.
REQ-032 When abort_=0 and start=1 coincide in IDLE, abort_ SHALL win and the burst SHALL not start.
REQ-033 rf_we_ SHALL be constant 1; the block SHALL never write the register file.

Reset
REQ-034 On reset_=0 the block SHALL immediately enter IDLE and drive m_valid=0, m_last=0, m_data=0, m_addr=0, rf_addr=0, busy=0, done=0, rf_we_=1.
REQ-035 Reset asserted mid-burst SHALL discard the burst with no done pulse, and the first start after reset_ rises SHALL be honoured.

Verification
REQ-036 The bench SHALL check: regfile preloaded ff[i]=i+0x100, start base=0 count=4, m_ready=1 -> words 0x100..0x103 on consecutive cycles, m_last on 0x103, done one cycle later.
REQ-037 The bench SHALL check: base=30 count=4 -> m_addr sequence 30, 31, 0, 1.
REQ-038 The bench SHALL check: m_ready toggling 1,0,0,1 -> no word lost or duplicated, m_data stable while stalled.
REQ-039 The bench SHALL check: count=40 -> exactly 32 beats; count=0 -> no m_valid and done the next cycle.
REQ-040 The bench SHALL check: abort_=0 after the 2nd beat -> m_valid=0 next cycle, no done, busy=0.
REQ-041 The bench SHALL check: reset_=0 mid-burst -> all outputs at reset values immediately, and a subsequent burst is correct.
